// File: rtl/mul4_tournament_scorer_if.sv
// ----------------------------------------------------------------------------
// mul4_tournament_scorer_if
//   Handshake bundle between the tournament scorer, the candidate under test
//   and the evolution controller.
//
//   Candidate side : in_valid, in_ready, in_id, in_y3..in_y0
//   Controller side: out_valid, out_ready, out_id, out_score, out_perfect
//
//   Modports:
//     slave  - the scorer (consumes candidates, produces winners)
//     master - the environment (produces candidates, consumes winners)
// ----------------------------------------------------------------------------
interface mul4_tournament_scorer_if #(
  parameter int ID_W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [ID_W-1:0] in_id;
  logic [15:0]     in_y3;
  logic [15:0]     in_y2;
  logic [15:0]     in_y1;
  logic [15:0]     in_y0;

  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic [6:0]      out_score;
  logic            out_perfect;

  modport slave (
    input  in_valid, in_id, in_y3, in_y2, in_y1, in_y0, out_ready,
    output in_ready, out_valid, out_id, out_score, out_perfect
  );

  modport master (
    output in_valid, in_id, in_y3, in_y2, in_y1, in_y0, out_ready,
    input  in_ready, out_valid, out_id, out_score, out_perfect
  );
endinterface

// File: rtl/mul4_tournament_scorer.sv
// ----------------------------------------------------------------------------
// mul4_tournament_scorer
//   Scores evolved 2x2-bit multiplier candidates against the exhaustive golden
//   product and runs tournament selection over groups of TOUR_SIZE candidates.
//
//   Parameters:
//     TOUR_SIZE - candidates per tournament (2..255)
//     ID_W      - candidate identifier width
//
//   Ports:
//     clk            - sole clock, rising edge
//     rst            - synchronous active-high reset
//     a1, a0, b1, b0 - constant exhaustive stimulus driven into the candidate
//     bus (slave)    - candidate results in, tournament winner out
//
//   Pipeline: S1 mismatch vector -> S2 score -> S3 best/count update.
//
//   Optional feature macro: MUL4_TOUR_EARLY_EXIT_EN
//     A score-64 candidate ends the tournament at once. Candidates are then
//     accepted only when the pipeline is empty so the early exit is exact.
// ----------------------------------------------------------------------------
module mul4_tournament_scorer #(
  parameter int TOUR_SIZE = 4,
  parameter int ID_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] a1,
  output logic [15:0] a0,
  output logic [15:0] b1,
  output logic [15:0] b0,
  mul4_tournament_scorer_if.slave bus
);

  // Lane i tests a = i[1:0], b = i[3:2]; golden bits are {y3, y2, y1, y0}.
  localparam logic [63:0] GOLDEN = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};
  localparam logic [7:0]  LAST   = 8'(TOUR_SIZE - 1);
  localparam logic [6:0]  PERFECT = 7'd64;

  typedef enum logic [1:0] {COLLECT, DRAIN, PRESENT} state_t;

  state_t          state, state_nxt;
  logic            in_rdy, out_vld, accept, busy;
  logic [7:0]      acc_cnt;
  logic            acc_last;

  logic            s1_v, s2_v;
  logic [63:0]     s1_mis;
  logic [ID_W-1:0] s1_id, s2_id;
  logic [6:0]      s1_score, s2_score;

  logic [7:0]      cnt;
  logic [6:0]      best_score, cand_score;
  logic [ID_W-1:0] best_id, cand_id;
  logic            take, win_load;

  assign a0 = 16'hAAAA;
  assign a1 = 16'hCCCC;
  assign b0 = 16'hF0F0;
  assign b1 = 16'hFF00;

  assign accept   = bus.in_valid && in_rdy;
  assign acc_last = (acc_cnt == LAST);

`ifdef MUL4_TOUR_EARLY_EXIT_EN
  // Tracks the cycle after the S3 update so a candidate is fully retired
  // before the next one enters; keeps the early exit free of stragglers.
  logic s3_v;
  always_ff @(posedge clk) begin
    if (rst) s3_v <= 1'b0;
    else     s3_v <= s2_v;
  end
  assign busy = s1_v || s2_v || s3_v;
`else
  assign busy = 1'b0;
`endif

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      COLLECT: begin
        in_rdy = !busy;
        if (win_load)                state_nxt = PRESENT;
        else if (accept && acc_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (win_load) state_nxt = PRESENT;
      end
      PRESENT: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;

  // Accept counter decides when the last candidate of a tournament is in.
  always_ff @(posedge clk) begin
    if (rst)           acc_cnt <= '0;
    else if (win_load) acc_cnt <= '0;
    else if (accept)   acc_cnt <= acc_last ? 8'd0 : acc_cnt + 8'd1;
  end

  // ---------------- S1 / S2 ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
    end
  end

  // NOTE: payload registers carry no reset; their valid bits gate every use,
  // so clearing them would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mis <= {bus.in_y3, bus.in_y2, bus.in_y1, bus.in_y0} ^ GOLDEN;
      s1_id  <= bus.in_id;
    end
    if (s1_v) begin
      s2_score <= s1_score;
      s2_id    <= s1_id;
    end
  end

  assign s1_score = PERFECT - 7'($countones(s1_mis));

  // ---------------- S3 ----------------
  always_comb begin
    // First arrival always loads; later ones need a strictly better score.
    take       = (cnt == 8'd0) || (s2_score > best_score);
    cand_score = take ? s2_score : best_score;
    cand_id    = take ? s2_id    : best_id;
`ifdef MUL4_TOUR_EARLY_EXIT_EN
    win_load   = s2_v && ((cnt == LAST) || (s2_score == PERFECT));
`else
    win_load   = s2_v && (cnt == LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      best_score      <= '0;
      best_id         <= '0;
      bus.out_id      <= '0;
      bus.out_score   <= '0;
      bus.out_perfect <= 1'b0;
    end else if (s2_v) begin
      if (win_load) begin
        bus.out_id      <= cand_id;
        bus.out_score   <= cand_score;
        bus.out_perfect <= (cand_score == PERFECT);
        cnt             <= '0;
        best_score      <= '0;
        best_id         <= '0;
      end else begin
        cnt        <= cnt + 8'd1;
        best_score <= cand_score;
        best_id    <= cand_id;
      end
    end
  end

endmodule

// File: tb/tb_mul4_tournament_scorer.sv
// ----------------------------------------------------------------------------
// tb_mul4_tournament_scorer
//   Directed bench for mul4_tournament_scorer (TOUR_SIZE=4, ID_W=8).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
//   Reference scores: golden = 64, all-zeros = 50, all-ones = 14
//   (golden carries 1+3+6+4 = 14 set bits).
// ----------------------------------------------------------------------------
module tb_mul4_tournament_scorer;

  localparam logic [63:0] GOLD = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};
  localparam logic [63:0] ZERO = 64'h0;
  localparam logic [63:0] ONES = {64{1'b1}};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a1, a0, b1, b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  mul4_tournament_scorer_if #(.ID_W(8)) bus ();

  mul4_tournament_scorer #(.TOUR_SIZE(4), .ID_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .a1  (a1),
    .a0  (a0),
    .b1  (b1),
    .b0  (b0),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus ports must hold their constants on every cycle.
  always @(negedge clk)
    check("stim", {a1, a0, b1, b0}, {16'hCCCC, 16'hAAAA, 16'hFF00, 16'hF0F0});

  // Present one candidate; it is accepted on the following rising edge.
  task automatic send(input logic [7:0] id, input logic [63:0] y);
    @(negedge clk);
    check($sformatf("in_ready_id%0d", id), 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_id    = id;
    {bus.in_y3, bus.in_y2, bus.in_y1, bus.in_y0} = y;
  endtask

  // Early-exit pacing: send, then confirm in_ready stays low for 3 cycles.
  task automatic send_spaced(input logic [7:0] id, input logic [63:0] y);
    send(id, y);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check($sformatf("busy_id%0d_c%0d", id, k), 64'(bus.in_ready), 64'd0);
    end
  endtask

  // Called right after the last send: checks latency, result, hold, handshake.
  task automatic finish_tour(input string tag, input logic [7:0] eid,
                             input logic [6:0] escore, input logic eperf,
                             input int hold);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_ov_c1"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ir_c1"}, 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check({tag, "_ov_c2"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_ov_c3"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_id"},    64'(bus.out_id), 64'(eid));
    check({tag, "_score"}, 64'(bus.out_score), 64'(escore));
    check({tag, "_perf"},  64'(bus.out_perfect), 64'(eperf));
    check({tag, "_ir_pr"}, 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_ov"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold"}, {bus.out_id, bus.out_score, bus.out_perfect},
            {eid, escore, eperf});
      check({tag, "_hold_ir"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ov_after"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ir_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_id     = '0;
    bus.in_y3     = '0;
    bus.in_y2     = '0;
    bus.in_y1     = '0;
    bus.in_y0     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outs", {bus.out_id, bus.out_score, bus.out_perfect}, 64'd0);

`ifndef MUL4_TOUR_EARLY_EXIT_EN
    // Golden among mixed candidates.
    send(8'd1, ZERO); send(8'd2, ONES); send(8'd3, GOLD); send(8'd4, ZERO);
    finish_tour("golden", 8'd3, 7'd64, 1'b1, 0);

    // Tie at 50 keeps the earlier id.
    send(8'd7, ZERO); send(8'd8, ZERO); send(8'd9, ONES); send(8'd10, ONES);
    finish_tour("tie", 8'd7, 7'd50, 1'b0, 0);

    // All-ones tournament with 10 cycles of backpressure.
    send(8'd30, ONES); send(8'd31, ONES); send(8'd32, ONES); send(8'd33, ONES);
    finish_tour("ones_bp", 8'd30, 7'd14, 1'b0, 10);

    // Reset mid-tournament discards two in-flight goldens.
    send(8'd11, GOLD); send(8'd12, GOLD);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ov", 64'(bus.out_valid), 64'd0);
    send(8'd19, ZERO); send(8'd20, GOLD); send(8'd21, ONES); send(8'd22, GOLD);
    finish_tour("midrst", 8'd20, 7'd64, 1'b1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst_single", 64'(bus.out_valid), 64'd0);
    end
`else
    // Perfect candidate ends the tournament after two entries.
    send_spaced(8'd1, ZERO);
    send(8'd2, GOLD);
    finish_tour("ee_exit", 8'd2, 7'd64, 1'b1, 0);

    // Following tournament counts four fresh candidates; tie keeps id 3.
    send_spaced(8'd3, ZERO);
    send_spaced(8'd4, ONES);
    send_spaced(8'd5, ZERO);
    send(8'd6, ONES);
    finish_tour("ee_next", 8'd3, 7'd50, 1'b0, 0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul4_tournament_scorer.md
# mul4_tournament_scorer

Scores evolved 2-bit × 2-bit vector-multiplier candidates and runs tournament selection over them. It sits directly downstream of each generated candidate individual and consumes that candidate's `y3..y0` lane vectors. It drives the fixed exhaustive stimulus vectors into the candidate. It scores each candidate's outputs against the golden product and emits the winner of every group of `TOUR_SIZE` candidates to the evolution controller.

## Interface
- `TOUR_SIZE`, 4: candidates per tournament (2..255).
- `ID_W`, 8: candidate identifier width.
- `clk` input 1: sole clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a1`, `a0`, `b1`, `b0` output 16 each: constant stimulus to the candidate.
- `in_valid` input 1: candidate result present.
- `in_ready` output 1: scorer accepts a result this cycle.
- `in_id` input ID_W: candidate identifier.
- `in_y3`, `in_y2`, `in_y1`, `in_y0` input 16 each: candidate outputs.
- `out_valid` output 1: tournament winner available.
- `out_ready` input 1: controller takes the winner.
- `out_id` output ID_W: winner identifier.
- `out_score` output 7: winner score (0..64).
- `out_perfect` output 1: winner score equals 64.

## Operation
- Lane i (0..15) encodes one test case: a = {i[1], i[0]}, b = {i[3], i[2]}.
- Stimulus values are fixed:
  - a0 = 0xAAAA
  - a1 = 0xCCCC
  - b0 = 0xF0F0
  - b1 = 0xFF00
- Golden product p = a*b (4 bits), with y_k[i] = p[k]:
  - y3 = 0x8000
  - y2 = 0x4C00
  - y1 = 0x6AC0
  - y0 = 0xA0A0
- Score = 64 − popcount of the 64-bit XOR between candidate and golden outputs. The result is unsigned, 7 bits, and never overflows.
- Pipeline:
  - S1 registers the 64-bit mismatch vector and id.
  - S2 registers score and id.
  - S3 compares against the best and updates best and count.
- Best update rule:
  - The first candidate of a tournament always loads the best.
  - Later candidates replace the best only on strictly greater score, so ties keep the earlier arrival.
- Candidate count runs 0..TOUR_SIZE−1.
  - When the S3 update processes count == TOUR_SIZE−1, the winner is loaded into the output registers and `out_valid` sets.
  - Count and best then clear.
- States:
  - IDLE/COLLECT: `in_ready` = 1.
  - DRAIN: the last candidate of the tournament has been accepted and is in flight; `in_ready` = 0.
  - PRESENT: `out_valid` = 1; `in_ready` = 0.
  - PRESENT → COLLECT on `out_valid && out_ready`.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid` = 0, `out_id` = 0, `out_score` = 0, `out_perfect` = 0.
  - Count = 0, best cleared, pipeline valids = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
- Reset mid-tournament discards all in-flight and partial results. The next tournament needs TOUR_SIZE fresh candidates.

## Timing
- Throughput: one candidate per cycle during COLLECT.
- Latency: `out_valid` is high 3 cycles after the edge that accepted the last candidate.
- `in_ready` is low from the cycle after the last accept until the cycle after the output handshake.
- No candidate is accepted in the same cycle as the output handshake.
- `in_ready` does not depend combinationally on `in_valid`.
- `out_valid` does not depend combinationally on `out_ready`.

## Configuration
- `MUL4_TOUR_EARLY_EXIT_EN`
  - Defined:
    - A candidate scoring 64 ends the tournament immediately; it becomes the winner regardless of count.
    - To keep this exact, `in_ready` is 0 while any candidate is in S1..S3, so throughput is one per 4 cycles.
    - `out_valid` asserts 3 cycles after that candidate's accept.
  - Undefined:
    - Every tournament processes exactly TOUR_SIZE candidates at full throughput.

## Test plan
1. Exhaustive golden check (TOUR_SIZE=4, macro undefined):
   - Stimulus: ids 1..4 carrying all-zeros, all-ones, golden, all-zeros on consecutive cycles.
   - Required response: `out_id`=3, `out_score`=64, `out_perfect`=1.
   - `out_valid` rises 3 cycles after the 4th accept.
2. Score arithmetic and tie:
   - Stimulus: ids 7, 8 all-zeros; ids 9, 10 all-ones.
   - Required response: `out_id`=7, `out_score`=50, `out_perfect`=0.
   - Separately, a tournament of four all-ones must yield `out_score`=14.
3. Backpressure:
   - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`.
   - Required response: `out_id`, `out_score` and `out_perfect` stay stable; `in_ready`=0 throughout.
   - `in_ready`=1 the cycle after the handshake.
4. Reset mid-tournament:
   - Stimulus: accept 2 candidates, pulse `rst` one cycle, then send 4 new candidates (golden at id 20).
   - Required response: exactly one output, `out_id`=20, `out_score`=64.
5. Early exit (`MUL4_TOUR_EARLY_EXIT_EN` defined):
   - Stimulus: id 1 all-zeros, id 2 golden.
   - Required response: output `out_id`=2, `out_score`=64 after 2 candidates.
   - The next tournament starts counting from the following candidate.
   - `in_ready` is low while each candidate is in flight.
6. Stimulus ports:
   - After reset, check `a0`=0xAAAA, `a1`=0xCCCC, `b0`=0xF0F0, `b1`=0xFF00.
   - These must be constant for all cycles.
